// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
// Sequencer and verdict checker for riscv-tests images on an RV32I core.
// Holds the core in reset, releases it, snoops the register-file write port
// for the done/result/test-number registers, applies a watchdog, and reports
// a one-cycle verdict. Optional regression totals are built only when the
// macro TEST_MON_STATS_EN is defined; otherwise they read as zero.
//
// Ports:
//   sys_clk_i, rst_n_i         clock, asynchronous active-low reset
//   start_i                    run one test (accepted only when idle)
//   clear_stats_i              synchronous clear of the pass/fail totals
//   rf_we_i/rf_waddr_i/rf_wdata_i  snooped core register-file write port
//   core_rst_n_o               active-low reset driven to the core
//   busy_o, done_o             sequencer busy, one-cycle verdict strobe
//   pass_o, timeout_o          verdict and watchdog cause
//   fail_testnum_o             last captured test number
//   cycle_count_o              RUN cycles of the last test
//   pass_cnt_o, fail_cnt_o     saturating regression totals

module riscv_test_monitor #(
   parameter int unsigned RESET_CYCLES   = 10,
   parameter int unsigned SETTLE_CYCLES  = 20,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned DONE_REG       = 26,
   parameter int unsigned RESULT_REG     = 27,
   parameter int unsigned TESTNUM_REG    = 3,
   parameter int unsigned CYC_W          = 32,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             sys_clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic             clear_stats_i,
   input  logic             rf_we_i,
   input  logic [4:0]       rf_waddr_i,
   input  logic [31:0]      rf_wdata_i,
   output logic             core_rst_n_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic             timeout_o,
   output logic [31:0]      fail_testnum_o,
   output logic [CYC_W-1:0] cycle_count_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o
);

   localparam int unsigned DCNT_MAX    = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
   localparam int unsigned DCNT_W      = $clog2(DCNT_MAX + 1);
   localparam int unsigned RESET_LOAD  = RESET_CYCLES - 1;
   localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
   localparam int unsigned TIMEOUT_LAST = TIMEOUT_CYCLES - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_SETTLE,
      S_REPORT
   } state_t;

   state_t            state;
   logic [DCNT_W-1:0] dcnt;
   logic [31:0]       result;

   logic        snoop;
   logic        wr_valid;
   logic        tn_hit;
   logic        res_hit;
   logic        done_hit;
   logic        timeout_hit;
   logic [31:0] result_nxt;

   // Snoop decode; writes to x0 never qualify.
   assign snoop       = (state == S_RUN) || (state == S_SETTLE);
   assign wr_valid    = rf_we_i && (rf_waddr_i != 5'd0);
   assign tn_hit      = snoop && wr_valid && (rf_waddr_i == 5'(TESTNUM_REG));
   assign res_hit     = snoop && wr_valid && (rf_waddr_i == 5'(RESULT_REG));
   assign done_hit    = (state == S_RUN) && wr_valid && (rf_waddr_i == 5'(DONE_REG))
                        && (rf_wdata_i != 32'd0);
   assign timeout_hit = (cycle_count_o == CYC_W'(TIMEOUT_LAST));
   // Verdict sees a result write landing in the very last snooping cycle.
   assign result_nxt  = res_hit ? rf_wdata_i : result;

   // Sequencer FSM with registered outputs.
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state          <= S_IDLE;
         dcnt           <= '0;
         result         <= '0;
         fail_testnum_o <= '0;
         cycle_count_o  <= '0;
         core_rst_n_o   <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         pass_o         <= 1'b0;
         timeout_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (tn_hit) begin
            fail_testnum_o <= rf_wdata_i;
         end
         if (res_hit) begin
            result <= rf_wdata_i;
         end
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  state          <= S_RESET;
                  busy_o         <= 1'b1;
                  dcnt           <= DCNT_W'(RESET_LOAD);
                  result         <= '0;
                  fail_testnum_o <= '0;
                  cycle_count_o  <= '0;
                  pass_o         <= 1'b0;
                  timeout_o      <= 1'b0;
               end
            end
            S_RESET: begin
               if (dcnt == DCNT_W'(0)) begin
                  state        <= S_RUN;
                  core_rst_n_o <= 1'b1;
               end else begin
                  dcnt <= dcnt - DCNT_W'(1);
               end
            end
            S_RUN: begin
               // A done write beats a simultaneous watchdog expiry.
               if (done_hit) begin
                  if (SETTLE_CYCLES == 0) begin
                     state  <= S_REPORT;
                     done_o <= 1'b1;
                     pass_o <= (result_nxt == 32'd1);
                  end else begin
                     state <= S_SETTLE;
                     dcnt  <= DCNT_W'(SETTLE_LOAD);
                  end
               end else if (timeout_hit) begin
                  state     <= S_REPORT;
                  done_o    <= 1'b1;
                  timeout_o <= 1'b1;
                  pass_o    <= 1'b0;
               end else begin
                  cycle_count_o <= cycle_count_o + CYC_W'(1);
               end
            end
            S_SETTLE: begin
               if (dcnt == DCNT_W'(0)) begin
                  state  <= S_REPORT;
                  done_o <= 1'b1;
                  pass_o <= (result_nxt == 32'd1);
               end else begin
                  dcnt <= dcnt - DCNT_W'(1);
               end
            end
            S_REPORT: begin
               state        <= S_IDLE;
               busy_o       <= 1'b0;
               core_rst_n_o <= 1'b0;
            end
            default: begin
               state        <= S_IDLE;
               busy_o       <= 1'b0;
               core_rst_n_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef TEST_MON_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Regression totals, bumped during the REPORT cycle; clear has priority.
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pass_cnt_o <= '0;
         fail_cnt_o <= '0;
      end else if (clear_stats_i) begin
         pass_cnt_o <= '0;
         fail_cnt_o <= '0;
      end else if (done_o) begin
         if (pass_o) begin
            if (pass_cnt_o != CNT_MAX) begin
               pass_cnt_o <= pass_cnt_o + CNT_W'(1);
            end
         end else if (fail_cnt_o != CNT_MAX) begin
            fail_cnt_o <= fail_cnt_o + CNT_W'(1);
         end
      end
   end
`else
   logic unused_clear_stats;

   assign unused_clear_stats = clear_stats_i;
   assign pass_cnt_o         = '0;
   assign fail_cnt_o         = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Testbench for riscv_test_monitor: directed and randomized test runs checked
// against a reference model that derives the verdict from the write sequence.

module tb_riscv_test_monitor;

   localparam int unsigned RC = 10;
   localparam int unsigned SC = 20;
   localparam int unsigned TC = 50;
   localparam int NW = 128;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        clr = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  wa = 5'd0;
   logic [31:0] wd = 32'd0;

   logic        core_rst_n, busy, done, pass, timeout;
   logic [31:0] testnum, cycle_count;
   logic [7:0]  pass_cnt, fail_cnt;

   int tests = 0;
   int fails = 0;
   int exp_pass_tot = 0;
   int exp_fail_tot = 0;

   logic        we_a [NW];
   logic [4:0]  wa_a [NW];
   logic [31:0] wd_a [NW];

   riscv_test_monitor #(
      .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC),
      .DONE_REG(26), .RESULT_REG(27), .TESTNUM_REG(3), .CYC_W(32), .CNT_W(8)
   ) dut (
      .sys_clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_stats_i(clr),
      .rf_we_i(we), .rf_waddr_i(wa), .rf_wdata_i(wd),
      .core_rst_n_o(core_rst_n), .busy_o(busy), .done_o(done), .pass_o(pass),
      .timeout_o(timeout), .fail_testnum_o(testnum), .cycle_count_o(cycle_count),
      .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_arrays();
      for (int k = 0; k < NW; k++) begin
         we_a[k] = 1'b0;
         wa_a[k] = 5'd0;
         wd_a[k] = 32'd0;
      end
   endtask

   task automatic put(input int k, input int a, input logic [31:0] d);
      we_a[k] = 1'b1;
      wa_a[k] = 5'(a);
      wd_a[k] = d;
   endtask

   task automatic gen_random();
      int a;
      for (int k = 0; k < NW; k++) begin
         case ($urandom_range(0, 4))
            0: a = 0;
            1: a = 3;
            2: a = 27;
            3: a = 26;
            default: a = int'($urandom_range(0, 31));
         endcase
         we_a[k] = 1'($urandom_range(0, 1));
         wa_a[k] = 5'(a);
         if (a == 26)
            wd_a[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
         else if (a == 27)
            wd_a[k] = 32'($urandom_range(0, 2));
         else
            wd_a[k] = $urandom;
      end
   endtask

   task automatic check_totals(input string tag);
      chk({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(exp_pass_tot));
      chk({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(exp_fail_tot));
   endtask

   // One complete test: reference verdict from the write table, then drive and compare.
   task automatic run_test(input bit do_clear, input int busy_start_k);
      int          k_end, last, done_k, seen;
      bit          hit, ep;
      logic [31:0] tn, res;
      hit   = 1'b0;
      k_end = TC - 1;
      for (int k = 0; k < TC; k++) begin
         if (we_a[k] && wa_a[k] == 5'd26 && wd_a[k] != 32'd0) begin
            k_end = k;
            hit   = 1'b1;
            break;
         end
      end
      last   = hit ? k_end + SC : k_end;
      done_k = last + 1;
      tn  = 32'd0;
      res = 32'd0;
      for (int k = 0; k <= last; k++) begin
         if (we_a[k] && wa_a[k] == 5'd3)  tn  = wd_a[k];
         if (we_a[k] && wa_a[k] == 5'd27) res = wd_a[k];
      end
      ep = hit && (res == 32'd1);
`ifdef TEST_MON_STATS_EN
      if (do_clear) begin
         exp_pass_tot = 0;
         exp_fail_tot = 0;
      end else if (ep) begin
         if (exp_pass_tot < 255) exp_pass_tot++;
      end else if (exp_fail_tot < 255) begin
         exp_fail_tot++;
      end
`endif

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("start_clears_testnum", 64'(testnum), 64'd0);
      chk("start_clears_cycles", 64'(cycle_count), 64'd0);
      chk("start_clears_pass", 64'(pass), 64'd0);
      chk("start_clears_timeout", 64'(timeout), 64'd0);

      // Reset phase: snooped writes here (even done writes) must be ignored.
      for (int i = 0; i < int'(RC); i++) begin
         chk("core_rst_low", 64'(core_rst_n), 64'd0);
         we = 1'b1;
         case ($urandom_range(0, 2))
            0: wa = 5'd3;
            1: wa = 5'd26;
            default: wa = 5'd27;
         endcase
         wd = 32'($urandom_range(1, 7));
         @(negedge clk);
      end
      we = 1'b0;
      chk("core_rst_released", 64'(core_rst_n), 64'd1);

      seen = -1;
      for (int k = 0; k < NW && seen < 0; k++) begin
         if (done === 1'b1) begin
            seen = k;
            chk("verdict_pass", 64'(pass), 64'(ep));
            chk("verdict_timeout", 64'(timeout), 64'(!hit));
            chk("verdict_testnum", 64'(testnum), 64'(tn));
            chk("verdict_cycles", 64'(cycle_count), 64'(k_end));
            chk("busy_at_done", 64'(busy), 64'd1);
            clr   = do_clear;
            start = (busy_start_k >= 0);
         end else begin
            start = (k == busy_start_k);
         end
         we = we_a[k];
         wa = wa_a[k];
         wd = wd_a[k];
         @(negedge clk);
         start = 1'b0;
         clr   = 1'b0;
         we    = 1'b0;
      end
      chk("done_cycle", 64'(seen), 64'(done_k));
      if (seen >= 0) begin
         chk("done_one_cycle", 64'(done), 64'd0);
         chk("busy_after_report", 64'(busy), 64'd0);
         chk("core_rst_after_report", 64'(core_rst_n), 64'd0);
         chk("pass_held", 64'(pass), 64'(ep));
         check_totals("report");
      end
   endtask

   task automatic mid_test_reset();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (RC) @(negedge clk);
      we = 1'b1;
      wa = 5'd3;
      wd = 32'h55;
      @(negedge clk);
      we = 1'b0;
      chk("run_capture_testnum", 64'(testnum), 64'h55);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_core_rst", 64'(core_rst_n), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_pass", 64'(pass), 64'd0);
      chk("abort_timeout", 64'(timeout), 64'd0);
      chk("abort_testnum", 64'(testnum), 64'd0);
      chk("abort_cycles", 64'(cycle_count), 64'd0);
      exp_pass_tot = 0;
      exp_fail_tot = 0;
      check_totals("abort");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      clear_arrays();
      repeat (3) @(negedge clk);
      chk("rst_core_rst", 64'(core_rst_n), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_timeout", 64'(timeout), 64'd0);
      chk("rst_testnum", 64'(testnum), 64'd0);
      chk("rst_cycles", 64'(cycle_count), 64'd0);
      check_totals("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Pass flow
      clear_arrays(); put(2, 3, 5); put(4, 27, 1); put(6, 26, 1);
      run_test(1'b0, -1);
      // Fail flow
      clear_arrays(); put(2, 3, 7); put(4, 27, 0); put(6, 26, 1);
      run_test(1'b0, -1);
      // Watchdog timeout
      clear_arrays(); put(5, 3, 11); put(7, 27, 1);
      run_test(1'b0, -1);
      // Late result write inside settle window; REPORT-cycle write ignored; x0 ignored
      clear_arrays(); put(1, 3, 9); put(2, 27, 0); put(3, 26, 1);
      put(8, 27, 1); put(9, 0, 1); put(24, 27, 0);
      run_test(1'b0, -1);
      // Result overwritten in the last settle cycle
      clear_arrays(); put(1, 27, 1); put(2, 26, 3); put(22, 27, 0);
      run_test(1'b0, -1);
      // Done write on the timeout cycle; start pulses while busy are dropped
      clear_arrays(); put(10, 27, 1); put(49, 26, 1);
      run_test(1'b0, 20);
      // Done data zero does not end the test
      clear_arrays(); put(3, 26, 0); put(4, 27, 1); put(6, 26, 2);
      run_test(1'b0, -1);
      // Clear totals together with a REPORT
      clear_arrays(); put(0, 27, 1); put(1, 26, 5);
      run_test(1'b1, -1);

      for (int n = 0; n < 20; n++) begin
         gen_random();
         run_test(($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 60)) : -1);
      end

      mid_test_reset();
      clear_arrays(); put(0, 3, 2); put(1, 27, 1); put(2, 26, 1);
      run_test(1'b0, -1);

`ifdef TEST_MON_STATS_EN
      // Drive the fail total to saturation and beyond
      clear_arrays(); put(0, 26, 1);
      while (exp_fail_tot < 255) run_test(1'b0, -1);
      run_test(1'b0, -1);
      chk("fail_cnt_saturated", 64'(fail_cnt), 64'd255);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable sequencer and verdict checker for running riscv-tests (rv32ui-p-*) images on the RV32I core. It sits beside the core and snoops the register-file write port. For each test it holds the core in reset, releases it, and waits for the done-register write. It then latches pass/fail, the failing test number and the cycle count, and enforces a watchdog timeout. It also keeps running pass/fail totals across a regression of tests.

## Interface
Parameters:
- RESET_CYCLES, 10: cycles core_rst_n_o is held low per test (≥1).
- SETTLE_CYCLES, 20: cycles of continued snooping after the done write, before the verdict (≥0).
- TIMEOUT_CYCLES, 100000: max RUN cycles before a timeout verdict (≥2).
- DONE_REG, 26: register whose nonzero write ends the test.
- RESULT_REG, 27: register holding the verdict; value 1 means pass.
- TESTNUM_REG, 3: register holding the current test number.
- CYC_W, 32: cycle counter width.
- CNT_W, 8: pass/fail total width.

Ports:
- sys_clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle request to run one test; ignored unless idle.
- clear_stats_i  in  1  synchronous clear of the pass/fail totals.
- rf_we_i  in  1  core register-file write enable.
- rf_waddr_i  in  5  write address.
- rf_wdata_i  in  32  write data.
- core_rst_n_o  out  1  active-low reset to the core.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle verdict strobe.
- pass_o  out  1  verdict; valid from done_o until the next accepted start.
- timeout_o  out  1  the verdict was caused by the watchdog.
- fail_testnum_o  out  32  last TESTNUM_REG value captured.
- cycle_count_o  out  CYC_W  RUN cycles of the last test.
- pass_cnt_o, fail_cnt_o  out  CNT_W  regression totals.

## Operation
- The FSM has five states: IDLE, RESET, RUN, SETTLE, REPORT.
- IDLE:
  - core_rst_n_o = 0.
  - On start_i: go to RESET, load the down-counter with RESET_CYCLES−1, and clear the captured result, testnum, cycle count, pass_o and timeout_o.
- RESET:
  - core_rst_n_o = 0.
  - When the counter reaches 0, go to RUN.
- RUN:
  - core_rst_n_o = 1; the cycle counter increments each cycle.
  - Snoop: when rf_we_i=1 and rf_waddr_i≠0, a matching TESTNUM_REG or RESULT_REG address captures rf_wdata_i.
  - A DONE_REG write with nonzero data goes to SETTLE and loads the settle counter.
  - If the cycle count reaches TIMEOUT_CYCLES−1 with no done write, go to REPORT with timeout set.
- SETTLE:
  - core_rst_n_o = 1; snooping continues, so a later write overwrites the captured values.
  - After SETTLE_CYCLES cycles, go to REPORT. With SETTLE_CYCLES=0, go directly to REPORT.
- REPORT:
  - done_o = 1.
  - pass_o = (result==1) && !timeout.
  - The totals update: pass_cnt_o or fail_cnt_o increments by 1 and saturates at all-ones.
  - Go to IDLE; core_rst_n_o returns to 0 in the next cycle.
- Simultaneous events:
  - A done write in the same cycle the timeout is reached: the done write wins.
  - clear_stats_i together with a REPORT increment: the clear wins and both totals become 0.
  - start_i while busy_o=1 is dropped.
- Writes to x0 are never captured.
- DONE_REG, RESULT_REG and TESTNUM_REG must be distinct and nonzero.

## Timing
- Reset values:
  - State IDLE, core_rst_n_o=0, busy_o=0, done_o=0, pass_o=0, timeout_o=0.
  - fail_testnum_o=0, cycle_count_o=0, pass_cnt_o=0, fail_cnt_o=0.
- All outputs are registered.
- start_i is sampled at edge T.
  - busy_o is high from T+1.
  - core_rst_n_o rises at T+1+RESET_CYCLES.
- A done write is sampled at edge D.
  - SETTLE starts at D+1.
  - done_o is high for exactly one cycle, at D+1+SETTLE_CYCLES.
  - busy_o falls one cycle after done_o.
- cycle_count_o freezes at the done write or timeout; it counts RUN cycles only.
- rst_n_i asserted mid-test aborts at once to IDLE with the reset values. The totals are lost and no done_o is issued.

## Configuration
- TEST_MON_STATS_EN defined:
  - pass_cnt_o and fail_cnt_o are implemented as above.
  - clear_stats_i is functional.
- TEST_MON_STATS_EN undefined:
  - No counter registers exist.
  - pass_cnt_o and fail_cnt_o are tied to 0.
  - clear_stats_i is ignored.
  - All other behaviour is unchanged.

## Test plan
- Pass flow: start, then RUN writes x3=5, x27=1, then x26=1 → done_o one cycle at D+21, pass_o=1, timeout_o=0, fail_testnum_o=5, pass_cnt_o=1.
- Fail flow: writes x3=7, x27=0, x26=1 → pass_o=0, fail_testnum_o=7, fail_cnt_o=1.
- Timeout: TIMEOUT_CYCLES=50, no x26 write → done_o with timeout_o=1, pass_o=0, cycle_count_o=49.
- Late write: x27=1 written 5 cycles after x26=1, inside the settle window → pass_o=1. A write to x0 of 1 → ignored.
- Edges:
  - start_i while busy → ignored.
  - Done write and timeout in the same cycle → timeout_o=0.
  - fail_cnt_o held at 255 and a fail → stays 255.
  - clear_stats_i with a REPORT → both totals 0.
- Mid-test rst_n_i low → core_rst_n_o=0, busy_o=0, all outputs 0. With TEST_MON_STATS_EN undefined → totals read 0 after a pass.
